fde_controller: RTL

Sequencing FSM for the fetch-decode-execute CPU. Drives the program counter and fetch-hold (stop) of the registered instruction memory, decodes the returned 16-bit instruction, and issues register-file read addresses, ALU operation and write-enable. Handles HALT, absolute jump, illegal opcodes, an external hold, and a retired-instruction counter.

---
 rtl/cpu_pkg.sv | 36 +++
 rtl/fde_decoder.sv | 38 +++
 rtl/fde_controller.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch-decode-execute CPU slice.
// Holds opcode values, ALU operation encodings, the controller state
// encoding and the bit positions of the 16-bit instruction fields.
package cpu_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int RS1_MSB = 11;
    localparam int RS1_LSB = 8;
    localparam int RS2_MSB = 7;
    localparam int RS2_LSB = 4;
    localparam int RD_MSB  = 3;
    localparam int RD_LSB  = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_HALT
    } state_t;

endpackage

// File: rtl/fde_decoder.sv
// Combinational opcode decoder.
// Ports:
//   opcode     in   4  instruction opcode field
//   alu_op     out  2  ALU operation (ADD for non-ALU opcodes)
//   is_alu     out  1  ADD/SUB/AND/OR
//   is_jmp     out  1  absolute jump
//   is_halt    out  1  halt
//   is_illegal out  1  opcode not defined by the ISA
module fde_decoder
    import cpu_pkg::*;
(
    input  logic [3:0] opcode,
    output logic [1:0] alu_op,
    output logic       is_alu,
    output logic       is_jmp,
    output logic       is_halt,
    output logic       is_illegal
);

    always_comb begin
        alu_op     = ALU_ADD;
        is_alu     = 1'b0;
        is_jmp     = 1'b0;
        is_halt    = 1'b0;
        is_illegal = 1'b0;
        case (opcode)
            OP_NOP:  ;
            OP_ADD:  begin is_alu = 1'b1; alu_op = ALU_ADD; end
            OP_SUB:  begin is_alu = 1'b1; alu_op = ALU_SUB; end
            OP_AND:  begin is_alu = 1'b1; alu_op = ALU_AND; end
            OP_OR:   begin is_alu = 1'b1; alu_op = ALU_OR;  end
            OP_JMP:  is_jmp  = 1'b1;
            OP_HALT: is_halt = 1'b1;
            default: is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/fde_controller.sv
// Sequencing FSM for the fetch-decode-execute CPU.
// Drives the instruction-memory address/hold, decodes the returned
// instruction and issues register-file addresses, ALU op and write strobe.
// Ports:
//   i_clk, i_reset       clock, async active-low reset
//   i_start              start pulse (accepted in IDLE/HALT)
//   i_hold               freeze everything while high
//   i_instruction [15:0] registered memory data, valid in DECODE
//   o_pc, o_stop         fetch address / memory hold (0 only in FETCH)
//   o_rs1, o_rs2, o_rd   register-file addresses
//   o_alu_op, o_rf_we    ALU operation / write strobe
//   o_busy, o_halted     status
//   o_illegal            sticky undefined-opcode flag
//   o_icount             saturating retired-instruction count
//
// state   | meaning
// IDLE    | waiting for i_start after reset
// FETCH   | memory released for one cycle, latches mem[o_pc]
// DECODE  | instruction valid, fields registered
// EXECUTE | write strobe, PC update, retire
// HALT    | stopped on HALT, waiting for i_start
module fde_controller
    import cpu_pkg::*;
#(
    parameter int PC_W     = 12,
    parameter int START_PC = 0,
    parameter int CNT_W    = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_hold,
    input  logic [15:0]      i_instruction,
    output logic [PC_W-1:0]  o_pc,
    output logic             o_stop,
    output logic [3:0]       o_rs1,
    output logic [3:0]       o_rs2,
    output logic [3:0]       o_rd,
    output logic [1:0]       o_alu_op,
    output logic             o_rf_we,
    output logic             o_busy,
    output logic             o_halted,
    output logic             o_illegal,
    output logic [CNT_W-1:0] o_icount
);

    state_t          state;
    logic            stop_q;
    logic            rf_we_q;
    logic            jmp_q;
    logic            halt_q;
    logic            illegal_q;
    logic [1:0]      dec_alu_op;
    logic            dec_is_alu;
    logic            dec_is_jmp;
    logic            dec_is_halt;
    logic            dec_is_illegal;
    logic [PC_W-1:0] jmp_pc;

    fde_decoder u_decoder (
        .opcode     (i_instruction[OPC_MSB:OPC_LSB]),
        .alu_op     (dec_alu_op),
        .is_alu     (dec_is_alu),
        .is_jmp     (dec_is_jmp),
        .is_halt    (dec_is_halt),
        .is_illegal (dec_is_illegal)
    );

    // The jump target is the registered rs1/rs2/rd fields, i.e. instr[11:0].
    assign jmp_pc = PC_W'({o_rs1, o_rs2, o_rd});

    // Hold overrides act immediately; the registered strobe survives the
    // hold so the write is reissued once it drops.
    assign o_stop  = stop_q | i_hold;
    assign o_rf_we = rf_we_q & ~i_hold;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state     <= S_IDLE;
            o_pc      <= PC_W'(START_PC);
            stop_q    <= 1'b1;
            o_rs1     <= '0;
            o_rs2     <= '0;
            o_rd      <= '0;
            o_alu_op  <= ALU_ADD;
            rf_we_q   <= 1'b0;
            jmp_q     <= 1'b0;
            halt_q    <= 1'b0;
            illegal_q <= 1'b0;
            o_busy    <= 1'b0;
            o_halted  <= 1'b0;
            o_illegal <= 1'b0;
            o_icount  <= '0;
        end else if (!i_hold) begin
            case (state)
                S_IDLE, S_HALT: begin
                    if (i_start) begin
                        state     <= S_FETCH;
                        o_pc      <= PC_W'(START_PC);
                        o_icount  <= '0;
                        o_illegal <= 1'b0;
                        stop_q    <= 1'b0;
                        o_busy    <= 1'b1;
                        o_halted  <= 1'b0;
                    end
                end
                S_FETCH: begin
                    state  <= S_DECODE;
                    stop_q <= 1'b1;
                end
                S_DECODE: begin
                    state     <= S_EXECUTE;
                    o_rs1     <= i_instruction[RS1_MSB:RS1_LSB];
                    o_rs2     <= i_instruction[RS2_MSB:RS2_LSB];
                    o_rd      <= i_instruction[RD_MSB:RD_LSB];
                    o_alu_op  <= dec_alu_op;
                    rf_we_q   <= dec_is_alu;
                    jmp_q     <= dec_is_jmp;
                    halt_q    <= dec_is_halt;
                    illegal_q <= dec_is_illegal;
                end
                S_EXECUTE: begin
                    rf_we_q <= 1'b0;
                    if (o_icount != {CNT_W{1'b1}}) begin
                        o_icount <= o_icount + 1'b1;
                    end
                    if (illegal_q) begin
                        o_illegal <= 1'b1;
                    end
                    if (halt_q) begin
                        state    <= S_HALT;
                        o_busy   <= 1'b0;
                        o_halted <= 1'b1;
                    end else begin
                        state  <= S_FETCH;
                        stop_q <= 1'b0;
                        o_pc   <= jmp_q ? jmp_pc : o_pc + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
